// File: rtl/ddr_burst_buffer_if.sv
// Capture-side and DDR-side signal bundle for ddr_burst_buffer.
// master drives the stimulus/DDR inputs, slave is the buffer itself.
interface ddr_burst_buffer_if #(
  parameter int DATA_W    = 12,
  parameter int CH        = 2,
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 32,
  parameter int CNT_W     = 25
);
  localparam int W  = CH * DATA_W;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  logic             I_start;
  logic [CNT_W-1:0] I_point_conf;
  logic             I_data_valid;
  logic [W-1:0]     I_data;
  logic             I_burst_grant;
  logic             I_ddr_ready;
  logic             O_burst_req;
  logic [BW-1:0]    O_burst_len;
  logic             O_rd_valid;
  logic [W-1:0]     O_rd_data;
  logic             O_rd_last;
  logic [LW-1:0]    O_level;
  logic             O_overflow;
  logic             O_done;

  modport master (
    output I_start, I_point_conf,
    output I_data_valid, I_data,
    output I_burst_grant, I_ddr_ready,
    input  O_burst_req, O_burst_len,
    input  O_rd_valid, O_rd_data, O_rd_last,
    input  O_level, O_overflow, O_done
  );

  modport slave (
    input  I_start, I_point_conf,
    input  I_data_valid, I_data,
    input  I_burst_grant, I_ddr_ready,
    output O_burst_req, O_burst_len,
    output O_rd_valid, O_rd_data, O_rd_last,
    output O_level, O_overflow, O_done
  );
endinterface

// File: rtl/ddr_burst_buffer.sv
// ADC capture FIFO that hands packed samples to DDR in bursts.
// Counts samples per armed run, flushes a final short burst.
module ddr_burst_buffer #(
  parameter int DATA_W    = 12,
  parameter int CH        = 2,
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 32,
  parameter int CNT_W     = 25
) (
  input logic I_clk,
  input logic I_rst,
  ddr_burst_buffer_if.slave bus
);
  localparam int W  = CH * DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE, REQ, XFER, DONE
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]     mem [DEPTH];
  logic [AW:0]      wp, rp;
  logic [LW-1:0]    level;
  logic             armed, run, ovf;
  logic [CNT_W-1:0] cnt, conf;
  logic [BW-1:0]    blen, beat;
  logic             full, empty, full_burst;
  logic             accept, wr, rd, last;
  logic             run_now, disarm_now;

  assign level      = wp - rp;
  assign full       = level == LW'(DEPTH);
  assign empty      = level == '0;
  assign full_burst = level >= LW'(BURST_LEN);
  assign rd         = (state == XFER) && bus.I_ddr_ready;
  assign last       = beat == blen - 1'b1;

  // Samples in the I_start cycle belong to neither run.
  assign accept = armed && bus.I_data_valid
               && (cnt < conf) && !bus.I_start;
  assign wr     = accept && (!full || rd);

  // Capture state as it will be after this edge.
  assign run_now    = run || bus.I_start;
  assign disarm_now = bus.I_start ? (bus.I_point_conf == '0)
                                  : !armed;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      armed <= 1'b0;
      run   <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      conf  <= '0;
    end else if (bus.I_start) begin
      armed <= bus.I_point_conf != '0;
      run   <= 1'b1;
      ovf   <= 1'b0;
      cnt   <= '0;
      conf  <= bus.I_point_conf;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (cnt + 1'b1 == conf) armed <= 1'b0;
      if (full && !rd) ovf <= 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (wr) mem[wp[AW-1:0]] <= bus.I_data;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      blen <= '0;
      beat <= '0;
    end else begin
      if (state == IDLE && state_nx == REQ)
        blen <= full_burst ? BW'(BURST_LEN)
                           : level[BW-1:0];
      if (state == REQ) beat <= '0;
      else if (rd)      beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (full_burst)
          state_nx = REQ;
        else if (run_now && disarm_now)
          state_nx = empty ? DONE : REQ;
      end
      REQ: begin
        if (bus.I_burst_grant) state_nx = XFER;
      end
      XFER: begin
        if (rd && last)
          state_nx = (run_now && disarm_now
                      && level == LW'(1))
                   ? DONE : IDLE;
      end
      DONE: begin
        if (bus.I_start && bus.I_point_conf != '0)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.O_burst_req = 1'b0;
    bus.O_rd_valid  = 1'b0;
    bus.O_rd_data   = '0;
    bus.O_rd_last   = 1'b0;
    bus.O_done      = 1'b0;
    bus.O_burst_len = blen;
    bus.O_level     = level;
    bus.O_overflow  = ovf;
    unique case (state)
      REQ:  bus.O_burst_req = 1'b1;
      XFER: begin
        bus.O_rd_valid = 1'b1;
        bus.O_rd_data  = mem[rp[AW-1:0]];
        bus.O_rd_last  = last;
      end
      DONE: bus.O_done = 1'b1;
      default: ;
    endcase
  end
endmodule
